// File: rtl/fmul_share_pkg.sv
// Shared types and helpers for the fmul_share_sched multiplier scheduler.
package fmul_share_pkg;

   localparam int unsigned FP_W = 32;

   typedef enum logic [1:0] {
      Idle,
      Busy,
      Done
   } slot_state_t;

   function automatic int unsigned tag_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr_i, cyclic.
module rr_arbiter #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned TW   = 1
) (
   input  logic [NREQ-1:0] elig_i,
   input  logic [TW-1:0]   ptr_i,
   output logic            gnt_vld_o,
   output logic [TW-1:0]   gnt_idx_o
);

   logic [TW-1:0] cand;

   // Walk from the farthest candidate back to ptr_i so the nearest eligible one wins.
   always_comb begin
      gnt_vld_o = 1'b0;
      gnt_idx_o = '0;
      cand      = '0;
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
         cand = TW'((int'(ptr_i) + k) % int'(NREQ));
         if (elig_i[cand]) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = cand;
         end
      end
   end

endmodule

// File: rtl/fmul_share_sched.sv
// Round-robin scheduler sharing one external FP32 multiplier among NREQ requesters.
// Optional FMUL_SHARE_STATS_EN adds grant and conflict counters.
module fmul_share_sched
   import fmul_share_pkg::*;
#(
   parameter int unsigned NREQ       = 2,
   parameter int unsigned PIPE_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*FP_W-1:0] req_x1,
   input  logic [NREQ*FP_W-1:0] req_x2,
   output logic [NREQ-1:0]      res_valid,
   input  logic [NREQ-1:0]      res_ready,
   output logic [NREQ*FP_W-1:0] res_y,
   output logic [FP_W-1:0]      fmul_x1,
   output logic [FP_W-1:0]      fmul_x2,
   input  logic [FP_W-1:0]      fmul_y
`ifdef FMUL_SHARE_STATS_EN
   ,
   output logic [31:0]          stat_issue,
   output logic [31:0]          stat_conflict
`endif
);

   localparam int unsigned TW = tag_w(NREQ);

   slot_state_t     slot_q [NREQ];
   slot_state_t     slot_d [NREQ];
   logic [NREQ-1:0] elig;
   logic            gnt_vld;
   logic [TW-1:0]   gnt_idx;
   logic [TW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [FP_W-1:0] x1_arr [NREQ];
   logic [FP_W-1:0] x2_arr [NREQ];
   logic [FP_W-1:0] x1_q, x2_q;
   logic [PIPE_DEPTH-1:0] vld_q;
   logic [TW-1:0]   tag_q [PIPE_DEPTH];
   logic            wb_vld;
   logic [TW-1:0]   wb_tag;
   logic [FP_W-1:0] wb_y;
   logic [FP_W-1:0] res_y_q [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_lane
      assign x1_arr[g]                = req_x1[g*FP_W +: FP_W];
      assign x2_arr[g]                = req_x2[g*FP_W +: FP_W];
      assign res_y[g*FP_W +: FP_W]    = res_y_q[g];
      assign res_valid[g]             = (slot_q[g] == Done);
   end

   // Reset also masks eligibility so req_ready reads 0 while rstn is low.
   always_comb begin
      elig = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         elig[i] = rstn && req_valid[i] && (slot_q[i] == Idle);
      end
   end

   rr_arbiter #(
      .NREQ (NREQ),
      .TW   (TW)
   ) u_arb (
      .elig_i    (elig),
      .ptr_i     (rr_ptr_q),
      .gnt_vld_o (gnt_vld),
      .gnt_idx_o (gnt_idx)
   );

   always_comb begin
      req_ready = '0;
      if (gnt_vld) begin
         req_ready[gnt_idx] = 1'b1;
      end
      rr_ptr_d = gnt_vld ? TW'((int'(gnt_idx) + 1) % int'(NREQ)) : rr_ptr_q;
   end

   assign fmul_x1 = x1_q;
   assign fmul_x2 = x2_q;
   assign wb_vld  = vld_q[PIPE_DEPTH-1];
   assign wb_tag  = tag_q[PIPE_DEPTH-1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr_q <= '0;
         x1_q     <= '0;
         x2_q     <= '0;
         vld_q    <= '0;
         for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         if (gnt_vld) begin
            x1_q <= x1_arr[gnt_idx];
            x2_q <= x2_arr[gnt_idx];
         end
         vld_q[0] <= gnt_vld;
         tag_q[0] <= gnt_idx;
         for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
            vld_q[k] <= vld_q[k-1];
            tag_q[k] <= tag_q[k-1];
         end
      end
   end

   // The result buffer is the last fmul_y stage, so only PIPE_DEPTH-1 data registers precede it.
   if (PIPE_DEPTH > 1) begin : g_dpipe
      logic [FP_W-1:0] dat_q [PIPE_DEPTH-1];
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            for (int k = 0; k < int'(PIPE_DEPTH) - 1; k++) begin
               dat_q[k] <= '0;
            end
         end else begin
            dat_q[0] <= fmul_y;
            for (int k = 1; k < int'(PIPE_DEPTH) - 1; k++) begin
               dat_q[k] <= dat_q[k-1];
            end
         end
      end
      assign wb_y = dat_q[PIPE_DEPTH-2];
   end else begin : g_dnopipe
      assign wb_y = fmul_y;
   end

   always_comb begin
      for (int i = 0; i < int'(NREQ); i++) begin
         slot_d[i] = slot_q[i];
         unique case (slot_q[i])
            Idle: if (gnt_vld && gnt_idx == TW'(i)) slot_d[i] = Busy;
            Busy: if (wb_vld && wb_tag == TW'(i)) slot_d[i] = Done;
            Done: if (res_ready[i]) slot_d[i] = Idle;
            default: slot_d[i] = Idle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            slot_q[i]  <= Idle;
            res_y_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NREQ); i++) begin
            slot_q[i] <= slot_d[i];
            if (wb_vld && wb_tag == TW'(i)) begin
               res_y_q[i] <= wb_y;
            end
         end
      end
   end

`ifdef FMUL_SHARE_STATS_EN
   logic [31:0] issue_q, conflict_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         issue_q    <= '0;
         conflict_q <= '0;
      end else begin
         issue_q    <= issue_q + {31'b0, gnt_vld};
         conflict_q <= conflict_q + {31'b0, ($countones(elig) > 1)};
      end
   end

   assign stat_issue    = issue_q;
   assign stat_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_fmul_share_sched.sv
// Self-checking bench for fmul_share_sched with a behavioural FP32 multiplier on fmul_*.
// Honours FMUL_SHARE_STATS_EN when the design is built with it.
module tb_fmul_share_sched;

   localparam int unsigned NREQ = 2;
   localparam int unsigned PD   = 2;

   logic              clk  = 1'b0;
   logic              rstn = 1'b0;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*32-1:0] req_x1, req_x2;
   logic [NREQ-1:0]   res_valid;
   logic [NREQ-1:0]   res_ready;
   logic [NREQ*32-1:0] res_y;
   logic [31:0]       fmul_x1, fmul_x2, fmul_y;
   logic [31:0]       x1_a [NREQ];
   logic [31:0]       x2_a [NREQ];
`ifdef FMUL_SHARE_STATS_EN
   logic [31:0]       stat_issue, stat_conflict;
`endif

   for (genvar g = 0; g < NREQ; g++) begin : g_drv
      assign req_x1[g*32 +: 32] = x1_a[g];
      assign req_x2[g*32 +: 32] = x2_a[g];
   end

   fmul_share_sched #(
      .NREQ       (NREQ),
      .PIPE_DEPTH (PD)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x1    (req_x1),
      .req_x2    (req_x2),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_y     (res_y),
      .fmul_x1   (fmul_x1),
      .fmul_x2   (fmul_x2),
      .fmul_y    (fmul_y)
`ifdef FMUL_SHARE_STATS_EN
      ,
      .stat_issue    (stat_issue),
      .stat_conflict (stat_conflict)
`endif
   );

   always #5 clk = ~clk;

   // Truncating FP32 multiply; zero exponent treated as signed zero.
   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      int          e;
      logic [47:0] p;
      logic [22:0] m;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
         m = p[46:24];
         e++;
      end else begin
         m = p[45:23];
      end
      return {s, e[7:0], m};
   endfunction

   always_comb fmul_y = fp_mul(fmul_x1, fmul_x2);

   typedef struct {
      int          tag;
      logic [31:0] y;
      int          cyc;
   } sb_t;

   typedef struct {
      int          r;
      logic [31:0] x1;
      logic [31:0] x2;
      logic [31:0] y;
   } vec_t;

   sb_t             sb[$];
   int              n_chk = 0;
   int              n_err = 0;
   int              cyc   = 0;
   int              grants [NREQ];
   logic [NREQ-1:0] rv_prev = '0;

   function automatic logic [31:0] lane(input logic [NREQ*32-1:0] v, input int i);
      return 32'(v >> (i * 32));
   endfunction

   function automatic int sb_find(input int tag);
      foreach (sb[k]) if (sb[k].tag == tag) return k;
      return -1;
   endfunction

   function automatic logic [31:0] rnd_op();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called just after inputs are driven at the falling edge; observes both handshakes.
   task automatic sample();
      int k;
      #1;
      chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      chk("ready_implies_valid", 32'(req_ready & ~req_valid), 32'd0);
      for (int i = 0; i < int'(NREQ); i++) begin
         if (res_valid[i] && !rv_prev[i]) begin
            k = sb_find(i);
            if (k < 0) begin
               n_chk++;
               n_err++;
               $display("FAIL spurious_res_valid slot %0d: got 1, expected 0 (cycle %0d)", i, cyc);
            end else begin
               chk("latency", 32'(cyc - sb[k].cyc), 32'(PD + 1));
            end
         end
         if (res_valid[i] && res_ready[i]) begin
            k = sb_find(i);
            if (k >= 0) begin
               chk("sb_res_y", lane(res_y, i), sb[k].y);
               sb.delete(k);
            end
         end
         if (req_valid[i] && req_ready[i]) begin
            chk("no_double_issue", 32'(sb_find(i) >= 0), 32'd0);
            sb.push_back('{tag: i, y: fp_mul(x1_a[i], x2_a[i]), cyc: cyc});
            grants[i]++;
         end
      end
   endtask

   task automatic tick();
      rv_prev = res_valid;
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain();
      int n;
      req_valid = '0;
      res_ready = '1;
      n = 0;
      while (sb.size() != 0 && n < 12) begin
         sample();
         tick();
         n++;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic apply_reset();
      rstn      = 1'b0;
      req_valid = '0;
      res_ready = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         x1_a[i] = '0;
         x2_a[i] = '0;
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      sb.delete();
      rv_prev = '0;
      cyc     = 0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin : main
      vec_t        tbl [6];
      int          r, w, got, last, g0, g1;
      logic [31:0] held;
`ifdef FMUL_SHARE_STATS_EN
      logic [31:0] conf0;
`endif

      tbl[0] = '{0, 32'h3FC00000, 32'h40000000, 32'h40400000};
      tbl[1] = '{1, 32'h00000000, 32'h7F000000, 32'h00000000};
      tbl[2] = '{1, 32'h80000000, 32'h7F000000, 32'h80000000};
      tbl[3] = '{0, 32'h40400000, 32'h40400000, 32'h41100000};
      tbl[4] = '{1, 32'hC0000000, 32'h3F000000, 32'hBF800000};
      tbl[5] = '{0, 32'h3F800000, 32'h3F800000, 32'h3F800000};
      for (int i = 0; i < int'(NREQ); i++) grants[i] = 0;

      req_valid = '0;
      res_ready = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         x1_a[i] = '0;
         x2_a[i] = '0;
      end
      @(negedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_y", 32'(res_y), 32'd0);
      chk("rst_fmul_x1", fmul_x1, 32'd0);
      chk("rst_fmul_x2", fmul_x2, 32'd0);
`ifdef FMUL_SHARE_STATS_EN
      chk("rst_stat_issue", stat_issue, 32'd0);
`endif
      apply_reset();

      // Single operations, one at a time, from the vector table.
      for (int t = 0; t < 6; t++) begin
         r            = tbl[t].r;
         req_valid    = '0;
         req_valid[r] = 1'b1;
         x1_a[r]      = tbl[t].x1;
         x2_a[r]      = tbl[t].x2;
         res_ready    = '1;
         sample();
         chk("tbl_ready", 32'(req_ready), 32'(1 << r));
         tick();
         req_valid = '0;
         got = 0;
         w   = 0;
         while (!got && w < 8) begin
            sample();
            if (res_valid[r]) begin
               chk("tbl_res_y", lane(res_y, r), tbl[t].y);
               chk("tbl_latency", 32'(w), 32'(PD));
               got = 1;
            end
            tick();
            w++;
         end
         chk("tbl_got_result", 32'(got), 32'd1);
         sample();
         chk("tbl_valid_cleared", 32'(res_valid[r]), 32'd0);
         chk("tbl_y_held", lane(res_y, r), tbl[t].y);
         tick();
      end

      // Both requesters always valid: grants must alternate.
`ifdef FMUL_SHARE_STATS_EN
      conf0 = stat_conflict;
`endif
      g0   = grants[0];
      g1   = grants[1];
      last = -1;
      res_ready = '1;
      for (int c = 0; c < 24; c++) begin
         req_valid = '1;
         for (int i = 0; i < int'(NREQ); i++) begin
            x1_a[i] = rnd_op();
            x2_a[i] = rnd_op();
         end
         sample();
         if (req_ready != '0) begin
            if (last >= 0) chk("alternate", 32'(req_ready[last]), 32'd0);
            last = req_ready[1] ? 1 : 0;
         end
         tick();
      end
      chk("both_grants0", 32'(grants[0] - g0), 32'd6);
      chk("both_grants1", 32'(grants[1] - g1), 32'd6);
`ifdef FMUL_SHARE_STATS_EN
      chk("both_conflict", stat_conflict - conf0, 32'd1);
`endif
      drain();

      // Requester 1 result held while requester 0 keeps issuing.
      res_ready = 2'b01;
      req_valid = '1;
      got = 0;
      w   = 0;
      while (!got && w < 10) begin
         x1_a[0] = rnd_op();
         x2_a[0] = rnd_op();
         sample();
         got = res_valid[1] ? 1 : 0;
         tick();
         w++;
      end
      chk("hold_seen", 32'(got), 32'd1);
      held = lane(res_y, 1);
      g0   = grants[0];
      for (int c = 0; c < 10; c++) begin
         x1_a[0] = rnd_op();
         x2_a[0] = rnd_op();
         x1_a[1] = rnd_op();
         x2_a[1] = rnd_op();
         sample();
         chk("hold_ready1", 32'(req_ready[1]), 32'd0);
         chk("hold_valid1", 32'(res_valid[1]), 32'd1);
         chk("hold_y1", lane(res_y, 1), held);
         tick();
      end
      chk("hold_req0_progress", 32'(grants[0] - g0 >= 2), 32'd1);
      drain();

      // Asynchronous reset while both slots are busy.
      req_valid = '1;
      x1_a[0] = rnd_op();
      x2_a[0] = rnd_op();
      x1_a[1] = rnd_op();
      x2_a[1] = rnd_op();
      sample();
      tick();
      sample();
      tick();
      req_valid = '0;
      rstn      = 1'b0;
      #1;
      chk("arst_req_ready", 32'(req_ready), 32'd0);
      chk("arst_res_valid", 32'(res_valid), 32'd0);
      chk("arst_res_y", 32'(res_y), 32'd0);
      chk("arst_fmul_x1", fmul_x1, 32'd0);
      chk("arst_fmul_x2", fmul_x2, 32'd0);
      sb.delete();
      rv_prev = '0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      cyc++;
      for (int c = 0; c < int'(PD) + 3; c++) begin
         sample();
         chk("arst_no_result", 32'(res_valid), 32'd0);
         tick();
      end

      // 100 operations from requester 0 alone.
      apply_reset();
      g0        = grants[0];
      res_ready = '1;
      req_valid = 2'b01;
      w = 0;
      while ((grants[0] - g0) < 100 && w < 1000) begin
         x1_a[0] = rnd_op();
         x2_a[0] = rnd_op();
         sample();
         tick();
         w++;
      end
      chk("solo_count", 32'(grants[0] - g0), 32'd100);
      drain();
`ifdef FMUL_SHARE_STATS_EN
      chk("stat_issue", stat_issue, 32'd100);
      chk("stat_conflict", stat_conflict, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
